jtcontra_gfx_romarb: RTL



---
 rtl/jtcontra_gfx_romarb.sv | 111 +++++++++++
 1 files changed

// File: rtl/jtcontra_gfx_romarb.sv
// Shares one SDRAM read port between two graphics engines: one cached word per engine,
// round-robin grant on ties. Define JTCONTRA_ROMARB_PRIO_EN to give engine 1 fixed priority.
module jtcontra_gfx_romarb #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gfx1_cs,
    input  logic [AW-1:0] gfx1_addr,
    output logic [DW-1:0] gfx1_data,
    output logic          gfx1_ok,
    input  logic          gfx2_cs,
    input  logic [AW-1:0] gfx2_addr,
    output logic [DW-1:0] gfx2_data,
    output logic          gfx2_ok,
    output logic          sdram_req,
    output logic [AW:0]   sdram_addr,
    input  logic [DW-1:0] sdram_data,
    input  logic          sdram_rdy
);

    typedef enum logic {StIdle, StWait} state_e;

    state_e        state_q;
    logic [AW-1:0] tag1_q, tag2_q, pend_addr_q;
    logic [DW-1:0] data1_q, data2_q;
    logic          valid1_q, valid2_q;
    logic          last_grant_q, pend_id_q;
    logic          sdram_req_q;
    logic [AW:0]   sdram_addr_q;

    logic          hit1, hit2, need1, need2;
    logic          grant_id;
    logic [AW-1:0] grant_addr;

    assign hit1  = valid1_q & (gfx1_addr == tag1_q);
    assign hit2  = valid2_q & (gfx2_addr == tag2_q);
    assign need1 = gfx1_cs & ~hit1;
    assign need2 = gfx2_cs & ~hit2;

    assign gfx1_ok    = gfx1_cs & hit1;
    assign gfx2_ok    = gfx2_cs & hit2;
    assign gfx1_data  = data1_q;
    assign gfx2_data  = data2_q;
    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;

    // Grant id: 0 selects engine 1, 1 selects engine 2.
    always_comb begin
        grant_id = 1'b0;
        if (need1 && need2) begin
`ifdef JTCONTRA_ROMARB_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant_q;
`endif
        end else if (need2) begin
            grant_id = 1'b1;
        end
        grant_addr = grant_id ? gfx2_addr : gfx1_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tag1_q       <= '0;
            tag2_q       <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            valid1_q     <= 1'b0;
            valid2_q     <= 1'b0;
            last_grant_q <= 1'b1;
            pend_id_q    <= 1'b0;
            pend_addr_q  <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (need1 || need2) begin
                        pend_id_q    <= grant_id;
                        pend_addr_q  <= grant_addr;
                        sdram_req_q  <= 1'b1;
                        sdram_addr_q <= {grant_id, grant_addr};
                        last_grant_q <= grant_id;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    // Tag with the address captured at grant time so a moved address misses.
                    if (sdram_rdy) begin
                        if (pend_id_q) begin
                            data2_q  <= sdram_data;
                            tag2_q   <= pend_addr_q;
                            valid2_q <= 1'b1;
                        end else begin
                            data1_q  <= sdram_data;
                            tag1_q   <= pend_addr_q;
                            valid1_q <= 1'b1;
                        end
                        sdram_req_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
